user_command_capture: RTL
=========================

Name: user_command_capture

Overview:
Parametrised player-input front end. It synchronises and debounces N active-low push-buttons and detects press events. Each press is turned into a gameCommand, which is held with a valid/ack handshake until the game controller consumes it. Sits between the board KEY pins and the game-control FSM. Presses are gated by turnIndicator.

Parameters:
N_KEYS, 2, number of buttons on KEY (min 2).
DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles needed to accept a level change (min 2; 1 ms at 50 MHz).
IDW, derived, max(1, $clog2(N_KEYS)), width of cmd_id; not overridable.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
turnIndicator  input  1  high = player's turn; presses accepted only while high.
KEY  input  N_KEYS  raw buttons, active-low (0 = pressed), asynchronous to clk.
cmd_ack  input  1  consumer accepts the current command (meaningful only while cmd_valid=1).
cmd_valid  output  1  command pending.
cmd_id  output  IDW  index of the key that produced the pending command.
command  output  gameCommand  id 0 -> HIT, id 1 -> STAND, id >= 2 -> NONE; NONE whenever cmd_valid=0.
dropped  output  1  sticky: a press was lost while a command was pending.
key_level  output  N_KEYS  debounced level per key, active-high (1 = held).

Behaviour:
- Reset (async assert, synchronous-safe release): sync flops = 1 (released); debounced state = all released; debounce counters = 0; FSM = IDLE; cmd_valid = 0, cmd_id = 0, command = NONE, dropped = 0, key_level = 0.
- Per key, 2-flop synchroniser. Per-key counter (width clog2(DEBOUNCE_CYCLES)):
  - synced level == debounced level: counter <= 0.
  - otherwise: counter increments.
  - on the cycle counter == DEBOUNCE_CYCLES-1 with the level still different: debounced level <= synced level, counter <= 0.
  - any glitch back to the debounced level restarts the count.
- Press event = debounced level goes released -> pressed (single-cycle, registered). Releases generate no event. A held key produces exactly one event.
- The debouncers run continuously regardless of turnIndicator. A key held across the start of a turn produces no event until it is released and re-pressed.
- Simultaneous press events in one cycle: the highest index wins (STAND beats HIT). The others are discarded and do not set dropped.
- Latency: pin stable low, first sampled at edge 0 -> cmd_valid=1 after edge DEBOUNCE_CYCLES+2, with cmd_id/command valid in the same cycle.
- FSM IDLE:
  - press event with turnIndicator=1 -> PENDING: cmd_valid <= 1, cmd_id/command loaded.
  - press with turnIndicator=0 is ignored.
  - cmd_ack is ignored.
- FSM PENDING:
  - cmd_id/command stay stable until leaving.
  - cmd_ack=1, no press -> IDLE next edge; cmd_valid <= 0, command <= NONE, cmd_id holds its last value, dropped <= 0.
  - cmd_ack=1 with a press event (turnIndicator=1) in the same cycle -> stay PENDING; load the new id/command; cmd_valid stays 1; dropped <= 0.
  - press event without cmd_ack -> press discarded, dropped <= 1.
  - turnIndicator=0 (takes priority over ack/press) -> IDLE next edge; cmd_valid <= 0, command <= NONE; dropped unchanged.
- dropped clears only on reset or an accepted cmd_ack.
- Reset mid-debounce or mid-PENDING: all state returns to reset values immediately. A key held through reset deassertion is debounced as a new press after DEBOUNCE_CYCLES+1 edges (+1 edge more for cmd_valid).
- Combinational decode from cmd_id to command. Registered outputs, apart from command. No combinational path from KEY or cmd_ack to any output.

Test Plan:
- DEBOUNCE_CYCLES=4, turnIndicator=1, KEY[0] low from edge 0 and held -> cmd_valid=1, cmd_id=0, command=HIT after edge 6. Holds until cmd_ack pulse, then cmd_valid=0, command=NONE next edge. No second event while still held.
- KEY[1] bounce (low 2 cycles, high 1, low 5) -> exactly one event, cmd_id=1, command=STAND. cmd_valid timed from the start of the final stable run.
- KEY[1:0] pressed in the same cycle -> single command STAND, dropped=0.
- KEY[0] pressed, no ack, then KEY[1] pressed -> command remains HIT, dropped=1. cmd_ack -> cmd_valid=0, dropped=0.
- turnIndicator=0, KEY[0] pressed -> cmd_valid stays 0. Then turnIndicator=1 while still held -> no command until release and re-press. Also: PENDING then turnIndicator=0 -> cmd_valid=0 next edge.
- N_KEYS=4: KEY[3] press -> cmd_id=3, command=NONE, cmd_valid=1. Assert reset mid-PENDING -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/user_command_capture.sv
// Player push-button front end: synchronise, debounce and edge-detect active-low keys,
// then hold the resulting game command under a valid/ack handshake.
package user_command_capture_pkg;
  typedef enum logic [1:0] {CMD_NONE = 2'd0, CMD_HIT = 2'd1, CMD_STAND = 2'd2} game_command_t;
endpackage

module user_command_capture
  import user_command_capture_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  localparam int IDW = ($clog2(N_KEYS) > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              turnIndicator,
  input  logic [N_KEYS-1:0] KEY,
  input  logic              cmd_ack,
  output logic              cmd_valid,
  output logic [IDW-1:0]    cmd_id,
  output game_command_t     command,
  output logic              dropped,
  output logic [N_KEYS-1:0] key_level
);
  localparam int CW = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic {IDLE, PENDING} state_t;

  logic [N_KEYS-1:0]         sync1, sync2, press;
  logic [N_KEYS-1:0][CW-1:0] cnt;
  logic [IDW-1:0]            sel;
  logic                      any_press;
  state_t                    state;

  // Synchronisers reset to the released (high) level so a held key is seen as a new press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      key_level <= '0;
      press     <= '0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        press[k] <= 1'b0;
        if (~sync2[k] == key_level[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          key_level[k] <= ~sync2[k];
          cnt[k]       <= '0;
          press[k]     <= ~sync2[k];
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // Ascending scan: the highest simultaneous press index wins.
  always_comb begin
    any_press = |press;
    sel       = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (press[i]) sel = IDW'(i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      dropped   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_press && turnIndicator) begin
            state     <= PENDING;
            cmd_valid <= 1'b1;
            cmd_id    <= sel;
          end
        end
        PENDING: begin
          if (!turnIndicator) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
          end else if (cmd_ack) begin
            dropped <= 1'b0;
            if (any_press) begin
              cmd_id <= sel;
            end else begin
              state     <= IDLE;
              cmd_valid <= 1'b0;
            end
          end else if (any_press) begin
            dropped <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    command = CMD_NONE;
    if (cmd_valid) begin
      if (cmd_id == IDW'(0))      command = CMD_HIT;
      else if (cmd_id == IDW'(1)) command = CMD_STAND;
    end
  end
endmodule
